// File: rtl/bitonic_sorter_16.sv
// rtl/bitonic_sorter_16.sv - fully pipelined 16-lane bitonic sorter with signed/unsigned mode
module bitonic_sorter_16 #(
    parameter int DATAWIDTH  = 8,
    parameter int DATALENGTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 sign_ctrl_i,
    input  logic [DATAWIDTH-1:0] x_i [DATALENGTH-1:0],
    output logic [DATAWIDTH-1:0] y_o [DATALENGTH-1:0]
);

    localparam int IW = $clog2(DATALENGTH);

    typedef logic [DATALENGTH-1:0][DATAWIDTH-1:0] pvec_t;

    // Comparison key: flipping the MSB maps two's complement order onto unsigned order.
    function automatic logic [DATAWIDTH-1:0] sort_key(
        input logic [DATAWIDTH-1:0] v,
        input logic                 sgn
    );
        sort_key = v ^ {sgn, {(DATAWIDTH-1){1'b0}}};
    endfunction

    // One bitonic merge phase p: p compare-exchange levels at distances 2^(p-1) .. 1.
    // Phases below 4 alternate block direction; phase 4 is ascending throughout.
    function automatic pvec_t merge_phase(
        input pvec_t v_in,
        input int    p,
        input logic  sgn
    );
        pvec_t                v;
        logic [DATAWIDTH-1:0] a;
        logic [DATAWIDTH-1:0] b;
        logic                 asc;
        logic                 swap;
        v = v_in;
        for (int s = 3; s >= 0; s--) begin
            if (s < p) begin
                for (int i = 0; i < DATALENGTH; i++) begin
                    if ((i & (1 << s)) == 0) begin
                        a    = v[IW'(i)];
                        b    = v[IW'(i + (1 << s))];
                        asc  = (p >= 4) || (((i >> p) & 1) == 0);
                        // Strict comparisons: equal keys never swap.
                        swap = asc ? (sort_key(a, sgn) > sort_key(b, sgn))
                                   : (sort_key(a, sgn) < sort_key(b, sgn));
                        if (swap) begin
                            v[IW'(i)]              = b;
                            v[IW'(i + (1 << s))]   = a;
                        end
                    end
                end
            end
        end
        merge_phase = v;
    endfunction

    pvec_t x_d, x_q;
    pvec_t p1_d, p1_q;
    pvec_t p2_d, p2_q;
    pvec_t p3_d, p3_q;
    pvec_t y_d, y_q;
    logic  s0_q, s1_q, s2_q, s3_q;

    // Flatten the input array and compute each phase from the previous register.
    always_comb begin
        x_d = '0;
        for (int i = 0; i < DATALENGTH; i++) begin
            x_d[IW'(i)] = x_i[IW'(i)];
        end
        p1_d = merge_phase(x_q,  1, s0_q);
        p2_d = merge_phase(p1_q, 2, s1_q);
        p3_d = merge_phase(p2_q, 3, s2_q);
        y_d  = merge_phase(p3_q, 4, s3_q);
    end

    // Pipeline registers; the mode bit travels with its vector so each sorts in its own mode.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            x_q  <= '0;
            p1_q <= '0;
            p2_q <= '0;
            p3_q <= '0;
            y_q  <= '0;
            s0_q <= 1'b0;
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            x_q  <= x_d;
            p1_q <= p1_d;
            p2_q <= p2_d;
            p3_q <= p3_d;
            y_q  <= y_d;
            s0_q <= sign_ctrl_i;
            s1_q <= s0_q;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // Present the output register as the unpacked result array.
    always_comb begin
        for (int i = 0; i < DATALENGTH; i++) begin
            y_o[IW'(i)] = y_q[IW'(i)];
        end
    end

endmodule

// File: tb/tb_bitonic_sorter_16.sv
// tb/tb_bitonic_sorter_16.sv - scoreboard bench for bitonic_sorter_16
module tb_bitonic_sorter_16;

    localparam int W = 8;
    localparam int N = 16;

    typedef logic [N*W-1:0] pv_t;
    typedef struct {
        int    target;
        pv_t   exp;
        string name;
    } ent_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         sgn;
    logic [W-1:0] x [N-1:0];
    logic [W-1:0] y [N-1:0];

    ent_t q[$];
    int   e      = 0;
    int   errors = 0;
    int   checks = 0;

    bitonic_sorter_16 #(.DATAWIDTH(W), .DATALENGTH(N)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .sign_ctrl_i (sgn),
        .x_i         (x),
        .y_o         (y)
    );

    always #5 clk = ~clk;

    always @(posedge clk) e <= e + 1;

    // List order: leftmost entry is element 15, rightmost is element 0.
    function automatic pv_t mk(input int a [16]);
        pv_t r;
        for (int k = 0; k < 16; k++) r[(15 - k)*W +: W] = W'(a[k]);
        return r;
    endfunction

    function automatic pv_t pack_y();
        pv_t r;
        for (int i = 0; i < N; i++) r[i*W +: W] = y[i];
        return r;
    endfunction

    // Apply one vector at a negedge; it is sampled at edge e+1 and emerges at edge e+5.
    task automatic drive(input pv_t v, input logic s, input logic r);
        @(negedge clk);
        rst = r;
        sgn = s;
        for (int i = 0; i < N; i++) x[i] = v[i*W +: W];
    endtask

    task automatic push(input int dt, input pv_t v, input string nm);
        ent_t en;
        en.target = e + dt;
        en.exp    = v;
        en.name   = nm;
        q.push_back(en);
    endtask

    task automatic send(input pv_t v, input logic s, input pv_t ex, input string nm);
        drive(v, s, 1'b0);
        push(5, ex, nm);
    endtask

    task automatic reset_cycle(input pv_t junk, input string nm);
        drive(junk, 1'b1, 1'b1);
        push(1, '0, nm);
    endtask

    task automatic release_with(input pv_t v, input logic s, input pv_t ex, input string nm);
        drive(v, s, 1'b0);
        push(1, '0, {nm, "_z1"});
        push(2, '0, {nm, "_z2"});
        push(3, '0, {nm, "_z3"});
        push(5 - 1, '0, {nm, "_z4"});
        push(5, ex, nm);
    endtask

    // Monitor: compare the output against every expectation due at this edge.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].target <= e) begin
            ent_t en;
            en = q.pop_front();
            checks++;
            if (en.target < e) begin
                errors++;
                $display("FAIL %s: missed at edge %0d (now %0d)", en.name, en.target, e);
            end else if (pack_y() !== en.exp) begin
                errors++;
                $display("FAIL %s: y_o=%h required=%h", en.name, pack_y(), en.exp);
            end
        end
    end

    pv_t v2, e2, v3, e3, v4, e4s, e4u, v5, e5s, e5u, junk;

    initial begin
        v2  = mk('{0, 18, 23, 35, 40, 60, 90, 95, 20, 14, 12, 10, 9, 8, 5, 3});
        e2  = mk('{95, 90, 60, 40, 35, 23, 20, 18, 14, 12, 10, 9, 8, 5, 3, 0});
        v3  = mk('{5, 7, 9, 1, 0, 2, 3, 6, 8, 15, 14, 12, 13, 10, 11, 4});
        e3  = mk('{15, 14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0});
        v4  = mk('{-100, -95, -90, -60, -40, -20, -18, -14, -8, -5, -1, 0, 5, 10, 25, 35});
        e4s = mk('{35, 25, 10, 5, 0, -1, -5, -8, -14, -18, -20, -40, -60, -90, -95, -100});
        e4u = mk('{-1, -5, -8, -14, -18, -20, -40, -60, -90, -95, -100, 35, 25, 10, 5, 0});
        v5  = mk('{-2, -15, -85, -6, 0, -52, -4, -1, 15, -57, 8, 10, 0, 1, 1, -45});
        e5s = mk('{15, 10, 8, 1, 1, 0, 0, -1, -2, -4, -6, -15, -45, -52, -57, -85});
        e5u = mk('{-1, -2, -4, -6, -15, -45, -52, -57, -85, 15, 10, 8, 1, 1, 0, 0});
        junk = mk('{-86, 17, 3, 99, -1, 42, 7, -128, 127, 64, 5, 6, 8, -9, 11, 33});

        rst = 1'b1;
        sgn = 1'b0;
        for (int i = 0; i < N; i++) x[i] = '0;

        // Reset held two cycles, then release into the first vector.
        reset_cycle(junk, "reset_a");
        reset_cycle(~junk, "reset_b");
        release_with(v2, 1'b0, e2, "first_after_reset");

        // Constant input held: output stays sorted.
        send(v2, 1'b0, e2, "hold_v2_a");
        send(v2, 1'b0, e2, "hold_v2_b");
        send(v2, 1'b0, e2, "hold_v2_c");

        // Individual directed vectors.
        send(v3, 1'b0, e3, "perm_unsigned");
        send(v4, 1'b1, e4s, "signed_sort");
        send(v5, 1'b1, e5s, "v5_signed");
        send(v5, 1'b0, e5u, "v5_unsigned");

        // Back-to-back streaming with the mode toggling every vector.
        send(v2, 1'b1, e2, "stream_v2_s");
        send(v3, 1'b0, e3, "stream_v3_u");
        send(v4, 1'b1, e4s, "stream_v4_s");
        send(v5, 1'b0, e5u, "stream_v5_u");
        send(v5, 1'b1, e5s, "stream_v5_s");
        send(v4, 1'b0, e4u, "stream_v4_u");
        send(v5, 1'b0, e5u, "stream_v5_u2");
        send(v4, 1'b1, e4s, "stream_v4_s2");

        // Mid-stream reset: four unchecked vectors in flight are discarded.
        drive(v4, 1'b0, 1'b0);
        drive(v5, 1'b1, 1'b0);
        drive(v2, 1'b0, 1'b0);
        drive(v3, 1'b1, 1'b0);
        reset_cycle(v5, "midstream_reset");
        release_with(v5, 1'b1, e5s, "after_mid_reset");

        // Drain with a bounded wait.
        for (int c = 0; c < 30 && q.size() > 0; c++) @(negedge clk);
        while (q.size() > 0) begin
            ent_t en;
            en = q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: timeout, expected at edge %0d, now %0d", en.name, en.target, e);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bitonic_sorter_16.md
# bitonic_sorter_16

Fully pipelined 16-element bitonic sorting network for the top-k datapath. Each cycle it accepts a vector of 16 DATAWIDTH-bit elements and, a fixed 4 cycles later, presents the same elements in ascending order. A per-vector control bit selects signed or unsigned comparison. There is no handshake: one vector in and one vector out every cycle.

## Interface

One clock; reset is synchronous and active-high.

**Parameters**
- `DATAWIDTH`, default 8: bit width of each element.
- `DATALENGTH`, default 16: number of elements. Fixed at 16; any other value is unsupported.

**Ports**
- `clk_i`, in, 1: clock. All state updates on the rising edge.
- `rst_i`, in, 1: synchronous, active-high reset.
- `sign_ctrl_i`, in, 1: comparison mode. 1 = two's-complement signed, 0 = unsigned. Sampled together with `x_i`.
- `x_i`, in, unpacked array [DATALENGTH-1:0] of [DATAWIDTH-1:0]: input vector.
- `y_o`, out, unpacked array [DATALENGTH-1:0] of [DATAWIDTH-1:0]: sorted vector. `y_o[0]` is the minimum and `y_o[15]` is the maximum.

## Operation

- Network: standard bitonic sort over 16 lanes, built in 4 phases.
  - Phase p (p = 1..4) bitonic-merges blocks of 2^p lanes.
  - Phase p has p compare-exchange steps, with distances 2^(p-1), ..., 1.
  - 10 steps in total, 8 compare-exchange units per step.
- Block direction:
  - Phases 1–3: blocks alternate direction, ascending for even block index and descending for odd block index (block index = lane >> p).
  - Phase 4: ascending across the whole vector.
- Compare-exchange (lower lane a, upper lane b, ascending): swap if a > b. Descending is the mirror case. Equal values never swap.
- Comparison mode:
  - Signed mode compares as two's complement. Implementation: invert the MSB of both operands, then compare unsigned.
  - Unsigned mode compares raw bits.
  - Elements are moved unmodified; only the comparison key is transformed.
- `sign_ctrl_i` is carried down the pipeline alongside its vector. Each vector is sorted entirely in the mode it was launched with, even if `sign_ctrl_i` changes on the very next cycle.
- Output is a permutation of the input: no element is lost, duplicated or altered, including duplicate values.

## Timing

- Pipeline registers sit at the input (`x_i` and `sign_ctrl_i`) and after phases 1, 2 and 3. Phase 4 is combinational from the phase-3 register into the output register.
- Result of each phase is registered at the next boundary. The output register drives `y_o`.
- Latency:
  - A vector sampled on rising edge N appears on `y_o` after rising edge N+4.
  - It is stable until edge N+5 if the input changes every cycle.
  - Throughput is 1 vector per cycle.
- Reset:
  - While `rst_i` = 1 at a rising edge, all pipeline registers, including the carried sign bits and `y_o`, become 0.
  - After reset is released, `y_o` stays all-zero until the first post-reset vector emerges 4 edges later.
  - Reset asserted mid-stream discards every in-flight vector. No partial results are produced.
- A constant `x_i` held for ≥4 cycles produces a constant, correctly sorted `y_o`.
- Timing target: each register stage contains at most 3 compare-exchange levels. Phase 4's 4 levels are allowed as the longest path.

## Test plan

1. **Reset.** Hold `rst_i` = 1 for 2 cycles with arbitrary `x_i` → `y_o` all 0. Release, apply a vector → `y_o` is 0 for edges 1–3 and sorted from edge 4.
2. **Unsigned sort.** `sign_ctrl_i` = 0, `x_i[15..0]` = 0,18,23,35,40,60,90,95,20,14,12,10,9,8,5,3 → `y_o[0..15]` = 0,3,5,8,9,10,12,14,18,20,23,35,40,60,90,95.
3. **Unsigned permutation.** `x_i[15..0]` = 5,7,9,1,0,2,3,6,8,15,14,12,13,10,11,4 → `y_o[i]` = i for all i.
4. **Signed sort.** `sign_ctrl_i` = 1, `x_i[15..0]` = -100,-95,-90,-60,-40,-20,-18,-14,-8,-5,-1,0,5,10,25,35 → `y_o[0..15]` = -100,-95,-90,-60,-40,-20,-18,-14,-8,-5,-1,0,5,10,25,35.
5. **Signed vs unsigned on the same vector.** `x_i[15..0]` = -2,-15,-85,-6,0,-52,-4,-1,15,-57,8,10,0,1,1,-45 (contains duplicates).
   - With `sign_ctrl_i` = 1 → `y_o[0..15]` = -85,-57,-52,-45,-15,-6,-4,-2,-1,0,0,1,1,8,10,15.
   - With `sign_ctrl_i` = 0 → `y_o[0..15]` = 0,0,1,1,8,10,15,171,199,204,211,241,250,252,254,255.
6. **Back-to-back streaming.** Apply vectors 2–5 on consecutive cycles, toggling `sign_ctrl_i` per vector → the four expected results appear on 4 consecutive cycles starting 4 edges after the first vector, each sorted in its own mode.
